// File: rtl/rf_write_arbiter_pkg.sv
// rf_write_arbiter_pkg: shared widths, write-entry type and one-hot helper for the register-bank write arbiter
package rf_write_arbiter_pkg;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;
   localparam int EXT_REG_DEF = 19;
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
      logic              ext_valid;
      logic [DATA_W-1:0] ext_data;
   } wr_entry_t;
   function automatic logic [31:0] onehot32(input logic [ADDR_W-1:0] a);
      return 32'(1) << a;
   endfunction
endpackage

// File: rtl/rf_wr_fifo.sv
// rf_wr_fifo: per-requester write FIFO; exposes every slot and its valid bit so the pending mask can see queued writes
module rf_wr_fifo
   import rf_write_arbiter_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    flush_i,
   input  logic                    push_i,
   input  logic                    pop_i,
   input  wr_entry_t               din_i,
   output wr_entry_t               dout_o,
   output logic                    full_o,
   output logic                    empty_o,
   output wr_entry_t [DEPTH-1:0]   mem_o,
   output logic [DEPTH-1:0]        vld_o
);
   localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
   logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
   logic [DEPTH-1:0] vld_q, vld_d;
   wr_entry_t [DEPTH-1:0] mem_q, mem_d;
   logic do_push, do_pop;
   function automatic logic [AW-1:0] nxt(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction
   // live slots are contiguous, so the valid bits alone give full/empty
   assign full_o  = &vld_q;
   assign empty_o = ~|vld_q;
   assign do_push = push_i & ~full_o & ~flush_i;
   assign do_pop  = pop_i & ~empty_o & ~flush_i;
   assign dout_o  = mem_q[rd_q];
   assign mem_o   = mem_q;
   assign vld_o   = vld_q;
   always_comb begin
      mem_d = mem_q;
      vld_d = vld_q;
      rd_d  = rd_q;
      wr_d  = wr_q;
      if (do_push) begin
         mem_d[wr_q] = din_i;
         vld_d[wr_q] = 1'b1;
         wr_d        = nxt(wr_q);
      end
      if (do_pop) begin
         vld_d[rd_q] = 1'b0;
         rd_d        = nxt(rd_q);
      end
      if (flush_i) begin
         vld_d = '0;
         rd_d  = '0;
         wr_d  = '0;
      end
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q <= '0;
         vld_q <= '0;
         rd_q  <= '0;
         wr_q  <= '0;
      end else begin
         mem_q <= mem_d;
         vld_q <= vld_d;
         rd_q  <= rd_d;
         wr_q  <= wr_d;
      end
   end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin sharing of the bank's single write port, with registered outputs,
// an extension-register shadow that every write re-drives, and a pending-write hazard mask
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int DEPTH   = 2,
   parameter int EXT_REG = EXT_REG_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     flush,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*ADDR_W-1:0]   req_addr,
   input  logic [NREQ*DATA_W-1:0]   req_data,
   input  logic [NREQ-1:0]          req_ext_valid,
   input  logic [NREQ*DATA_W-1:0]   req_ext_data,
   output logic                     RegWrite,
   output logic [ADDR_W-1:0]        wrAddr,
   output logic [DATA_W-1:0]        wrData,
   output logic [DATA_W-1:0]        wrDataExt,
   output logic [31:0]              pending_mask,
   output logic [DATA_W-1:0]        ext_shadow
);
   localparam int PW = $clog2(NREQ);
   localparam logic [ADDR_W-1:0] EXT_A = ADDR_W'(EXT_REG);
   logic [NREQ-1:0] full, empty, pop;
   wr_entry_t head [NREQ];
   wr_entry_t [DEPTH-1:0] mem [NREQ];
   logic [DEPTH-1:0] vld [NREQ];
   logic gnt, go;
   logic [PW-1:0] gnt_idx, ptr_q, ptr_d;
   wr_entry_t sel;
   logic rw_q, rw_d, sext_q, sext_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] data_q, data_d, ext_q, ext_d;
   for (genvar g = 0; g < NREQ; g++) begin : g_fifo
      wr_entry_t din;
      assign din = '{addr: req_addr[g*ADDR_W +: ADDR_W], data: req_data[g*DATA_W +: DATA_W],
                     ext_valid: req_ext_valid[g], ext_data: req_ext_data[g*DATA_W +: DATA_W]};
      assign req_ready[g] = ~full[g];
      rf_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
         .clk(clk), .reset(reset), .flush_i(flush), .push_i(req_valid[g]), .pop_i(pop[g]),
         .din_i(din), .dout_o(head[g]), .full_o(full[g]), .empty_o(empty[g]),
         .mem_o(mem[g]), .vld_o(vld[g])
      );
   end
   always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NREQ; k++)
         if (!gnt && !empty[(int'(ptr_q) + k) % NREQ]) begin
            gnt     = 1'b1;
            gnt_idx = PW'((int'(ptr_q) + k) % NREQ);
         end
   end
   assign go  = gnt & ~flush;
   assign sel = head[gnt_idx];
   // explicit ext data beats a direct write to the extension register, matching bank write order
   always_comb begin
      pop          = '0;
      pop[gnt_idx] = go;
      rw_d         = go;
      addr_d       = go ? sel.addr : addr_q;
      data_d       = go ? sel.data : data_q;
      sext_d       = go ? sel.ext_valid : sext_q;
      ext_d        = !go ? ext_q : sel.ext_valid ? sel.ext_data : (sel.addr == EXT_A) ? sel.data : ext_q;
      ptr_d        = !go ? ptr_q : (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rw_q   <= 1'b0;
         addr_q <= '0;
         data_q <= '0;
         sext_q <= 1'b0;
         ext_q  <= '0;
         ptr_q  <= '0;
      end else begin
         rw_q   <= rw_d;
         addr_q <= addr_d;
         data_q <= data_d;
         sext_q <= sext_d;
         ext_q  <= ext_d;
         ptr_q  <= ptr_d;
      end
   end
   always_comb begin
      pending_mask = '0;
      if (rw_q) pending_mask = onehot32(addr_q) | (sext_q ? onehot32(EXT_A) : '0);
      for (int i = 0; i < NREQ; i++)
         for (int j = 0; j < DEPTH; j++)
            if (vld[i][j])
               pending_mask = pending_mask | onehot32(mem[i][j].addr) | (mem[i][j].ext_valid ? onehot32(EXT_A) : '0);
   end
   assign RegWrite   = rw_q;
   assign wrAddr     = addr_q;
   assign wrData     = data_q;
   assign wrDataExt  = ext_q;
   assign ext_shadow = ext_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed vectors with hand-computed expectations for the write arbiter
module tb_rf_write_arbiter;
   logic clk = 1'b0, reset = 1'b0, flush = 1'b0;
   logic [1:0] req_valid, req_ready, req_ext_valid;
   logic [9:0] req_addr;
   logic [63:0] req_data, req_ext_data;
   logic RegWrite;
   logic [4:0] wrAddr;
   logic [31:0] wrData, wrDataExt, pending_mask, ext_shadow;
   int n_vec = 0, n_err = 0;
   logic [4:0] log_a[$];
   logic [31:0] log_d[$];

   rf_write_arbiter dut (
      .clk(clk), .reset(reset), .flush(flush), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_data(req_data), .req_ext_valid(req_ext_valid), .req_ext_data(req_ext_data),
      .RegWrite(RegWrite), .wrAddr(wrAddr), .wrData(wrData), .wrDataExt(wrDataExt),
      .pending_mask(pending_mask), .ext_shadow(ext_shadow)
   );

   always #5 clk = ~clk;
   always @(negedge clk)
      if (RegWrite) begin
         log_a.push_back(wrAddr);
         log_d.push_back(wrData);
      end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic clr();
      req_valid = '0;
      req_addr = '0;
      req_data = '0;
      req_ext_valid = '0;
      req_ext_data = '0;
   endtask
   task automatic drive(input int r, input logic [4:0] a, input logic [31:0] d, input logic ev, input logic [31:0] ed);
      req_valid[r] = 1'b1;
      req_addr[r*5 +: 5] = a;
      req_data[r*32 +: 32] = d;
      req_ext_valid[r] = ev;
      req_ext_data[r*32 +: 32] = ed;
   endtask
   function automatic logic [31:0] bit_(input int n);
      return 32'(1) << n;
   endfunction

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic [4:0]  a0[4] = '{5'd8, 5'd9, 5'd10, 5'd11};
      logic [4:0]  a1[4] = '{5'd12, 5'd13, 5'd14, 5'd15};
      logic [31:0] d0[4] = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
      logic [31:0] d1[4] = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
      logic [1:0] rdy;
      int i0 = 0, i1 = 0, cyc = 0;
      clr();
      #3 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_rw", 32'(RegWrite), 0);
      chk("rst_addr", 32'(wrAddr), 0);
      chk("rst_data", wrData, 0);
      chk("rst_ext", wrDataExt, 0);
      chk("rst_shadow", ext_shadow, 0);
      chk("rst_pend", pending_mask, 0);
      reset = 1'b0;
      tick();
      chk("rst_ready", 32'(req_ready), 3);

      // single write, latency
      drive(0, 5'd5, 32'hAA, 1'b0, 0);
      tick();
      clr();
      chk("t1_nobypass", 32'(RegWrite), 0);
      chk("t1_pend_q", pending_mask, bit_(5));
      tick();
      chk("t1_rw", 32'(RegWrite), 1);
      chk("t1_addr", 32'(wrAddr), 5);
      chk("t1_data", wrData, 32'hAA);
      chk("t1_ext", wrDataExt, 0);
      chk("t1_pend_s", pending_mask, bit_(5));
      tick();
      chk("t1_rw_low", 32'(RegWrite), 0);
      chk("t1_addr_hold", 32'(wrAddr), 5);

      // ext write then plain write re-drives the shadow
      drive(1, 5'd3, 32'h33, 1'b1, 32'h1234);
      tick();
      clr();
      drive(0, 5'd4, 32'h44, 1'b0, 0);
      tick();
      clr();
      chk("t2_addr1", 32'(wrAddr), 3);
      chk("t2_ext1", wrDataExt, 32'h1234);
      chk("t2_pend1", pending_mask, bit_(3) | bit_(19) | bit_(4));
      tick();
      chk("t2_addr2", 32'(wrAddr), 4);
      chk("t2_data2", wrData, 32'h44);
      chk("t2_ext2", wrDataExt, 32'h1234);
      chk("t2_shadow", ext_shadow, 32'h1234);
      chk("t2_pend2", pending_mask, bit_(4));
      tick();

      // both requesters streaming; pointer is 1 here so requester 1 goes first
      log_a.delete();
      log_d.delete();
      while ((i0 < 4 || i1 < 4) && cyc < 40) begin
         clr();
         if (i0 < 4) drive(0, a0[i0], d0[i0], 1'b0, 0);
         if (i1 < 4) drive(1, a1[i1], d1[i1], 1'b0, 0);
         rdy = req_ready;
         tick();
         cyc++;
         if (i0 < 4 && rdy[0]) i0++;
         if (i1 < 4 && rdy[1]) i1++;
      end
      clr();
      while (log_a.size() < 8 && cyc < 60) begin
         tick();
         cyc++;
      end
      repeat (3) tick();
      chk("t3_count", 32'(log_a.size()), 8);
      for (int k = 0; k < 8; k++) begin
         if (k < log_a.size()) begin
            chk($sformatf("t3_addr%0d", k), 32'(log_a[k]), 32'((k % 2) ? a0[k/2] : a1[k/2]));
            chk($sformatf("t3_data%0d", k), log_d[k], (k % 2) ? d0[k/2] : d1[k/2]);
         end
      end
      chk("t3_ext_keep", wrDataExt, 32'h1234);

      // direct r19 writes
      drive(0, 5'd19, 32'hDEAD, 1'b0, 0);
      tick();
      clr();
      tick();
      chk("t4_data", wrData, 32'hDEAD);
      chk("t4_ext", wrDataExt, 32'hDEAD);
      chk("t4_shadow", ext_shadow, 32'hDEAD);
      drive(0, 5'd19, 32'h1111, 1'b1, 32'hBEEF);
      tick();
      clr();
      tick();
      chk("t4_data2", wrData, 32'h1111);
      chk("t4_ext2", wrDataExt, 32'hBEEF);
      chk("t4_pend", pending_mask, bit_(19));
      tick();

      // fill requester 0 while requester 1 takes the grant
      drive(0, 5'd2, 32'h22, 1'b1, 32'h5555);
      drive(1, 5'd10, 32'h100, 1'b0, 0);
      tick();
      clr();
      drive(0, 5'd6, 32'h66, 1'b0, 0);
      tick();
      clr();
      chk("t5_ready", 32'(req_ready), 2);
      chk("t5_addr_r1", 32'(wrAddr), 10);
      chk("t5_pend_full", pending_mask, bit_(2) | bit_(19) | bit_(6) | bit_(10));
      drive(0, 5'd12, 32'hCC, 1'b0, 0);
      tick();
      clr();
      chk("t5_addr_a", 32'(wrAddr), 2);
      chk("t5_ext_a", wrDataExt, 32'h5555);
      chk("t5_pend_drop", pending_mask, bit_(6) | bit_(2) | bit_(19));
      tick();
      chk("t5_addr_b", 32'(wrAddr), 6);
      chk("t5_ext_b", wrDataExt, 32'h5555);
      tick();
      chk("t5_idle_rw", 32'(RegWrite), 0);
      chk("t5_idle_pend", pending_mask, 0);

      // flush with three queued and one staged
      drive(0, 5'd7, 32'h77, 1'b0, 0);
      drive(1, 5'd8, 32'h88, 1'b0, 0);
      tick();
      clr();
      drive(0, 5'd9, 32'h99, 1'b0, 0);
      drive(1, 5'd11, 32'hBB, 1'b0, 0);
      tick();
      clr();
      chk("t6_staged_rw", 32'(RegWrite), 1);
      chk("t6_staged_addr", 32'(wrAddr), 8);
      chk("t6_pend", pending_mask, bit_(7) | bit_(9) | bit_(11) | bit_(8));
      flush = 1'b1;
      drive(1, 5'd13, 32'hDD, 1'b0, 0);
      tick();
      flush = 1'b0;
      clr();
      log_a.delete();
      log_d.delete();
      chk("t6_flush_rw", 32'(RegWrite), 0);
      chk("t6_flush_pend", pending_mask, 0);
      chk("t6_flush_ready", 32'(req_ready), 3);
      chk("t6_flush_shadow", ext_shadow, 32'h5555);
      repeat (3) tick();
      chk("t6_no_writes", 32'(log_a.size()), 0);

      // asynchronous reset mid-stream
      drive(0, 5'd19, 32'h0101, 1'b1, 32'h7777);
      tick();
      clr();
      drive(0, 5'd20, 32'h0202, 1'b0, 0);
      tick();
      clr();
      chk("t7_ext_pre", wrDataExt, 32'h7777);
      chk("t7_pend_pre", pending_mask, bit_(19) | bit_(20));
      #2 reset = 1'b1;
      #1;
      chk("t7_rw", 32'(RegWrite), 0);
      chk("t7_addr", 32'(wrAddr), 0);
      chk("t7_data", wrData, 0);
      chk("t7_ext", wrDataExt, 0);
      chk("t7_shadow", ext_shadow, 0);
      chk("t7_pend", pending_mask, 0);
      #1 reset = 1'b0;
      log_a.delete();
      log_d.delete();
      repeat (2) tick();
      chk("t7_lost", 32'(log_a.size()), 0);
      chk("t7_ready", 32'(req_ready), 3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
